// File: rtl/fp_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : fp_regfile_sb
// Brief    : Parametrised 3-read/1-write FP register file with a per-register
//            pending (scoreboard) bit. Define FP_RF_BYPASS_EN for write-to-read
//            forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module fp_regfile_sb #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int ZERO_R0 = 0,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     rs1_addr,
    input  logic [AW-1:0]     rs2_addr,
    input  logic [AW-1:0]     rs3_addr,
    output logic [XLEN-1:0]   rd_data1,
    output logic [XLEN-1:0]   rd_data2,
    output logic [XLEN-1:0]   rd_data3,
    output logic              busy1,
    output logic              busy2,
    output logic              busy3,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              issue_en,
    input  logic [AW-1:0]     issue_rd,
    output logic              waw_hazard,
    output logic [NREGS-1:0]  pending_vec
);

    localparam logic [AW:0] c_nRegs = (AW+1)'(NREGS);

    // A "live" address maps to a real, writable register: in range and not a hardwired r0.
    function automatic logic isLive(input logic [AW-1:0] addr);
        return ({1'b0, addr} < c_nRegs) && !((ZERO_R0 != 0) && (addr == '0));
    endfunction

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_pending;
    logic             w_wrLive;
    logic             w_issueLive;

    assign w_wrLive    = wr_en && isLive(wr_addr);
    assign w_issueLive = issue_en && isLive(issue_rd);

    // Issue is applied after writeback so a new outstanding producer keeps the bit set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pending <= '0;
        end else begin
            if (w_wrLive) begin
                r_regs[wr_addr]    <= wr_data;
                r_pending[wr_addr] <= 1'b0;
            end
            if (w_issueLive) begin
                r_pending[issue_rd] <= 1'b1;
            end
        end
    end

    assign waw_hazard  = w_issueLive && r_pending[issue_rd];
    assign pending_vec = r_pending;

    logic [AW-1:0]   w_rsAddr [3];
    logic [XLEN-1:0] w_rdData [3];
    logic            w_busy   [3];

    assign w_rsAddr[0] = rs1_addr;
    assign w_rsAddr[1] = rs2_addr;
    assign w_rsAddr[2] = rs3_addr;

    for (genvar k = 0; k < 3; k++) begin : g_rdPort
        logic w_live;
        logic w_wrHit;

        assign w_live    = isLive(w_rsAddr[k]);
        assign w_wrHit   = wr_en && (wr_addr == w_rsAddr[k]);
        assign w_busy[k] = w_live && r_pending[w_rsAddr[k]] && !w_wrHit;
`ifdef FP_RF_BYPASS_EN
        assign w_rdData[k] = !w_live ? '0 : (w_wrHit ? wr_data : r_regs[w_rsAddr[k]]);
`else
        assign w_rdData[k] = w_live ? r_regs[w_rsAddr[k]] : '0;
`endif
    end

    assign rd_data1 = w_rdData[0];
    assign rd_data2 = w_rdData[1];
    assign rd_data3 = w_rdData[2];
    assign busy1    = w_busy[0];
    assign busy2    = w_busy[1];
    assign busy3    = w_busy[2];

endmodule
`default_nettype wire

// File: tb/tb_fp_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_regfile_sb
// Brief    : Directed self-checking bench for fp_regfile_sb; instance A is the
//            default 32x32 bank, instance B is 64-bit, 24 entries, r0 hardwired.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1, rs2, rs3;
    logic        wrEn;
    logic [4:0]  wrAddr;
    logic [63:0] wrData;
    logic        issueEn;
    logic [4:0]  issueRd;

    logic [31:0] aRd1, aRd2, aRd3;
    logic        aBusy1, aBusy2, aBusy3, aWaw;
    logic [31:0] aPend;
    logic [63:0] bRd1, bRd2, bRd3;
    logic        bBusy1, bBusy2, bBusy3, bWaw;
    logic [23:0] bPend;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_regfile_sb #(.XLEN(32), .NREGS(32), .ZERO_R0(0)) u_dutA (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1), .rs2_addr(rs2), .rs3_addr(rs3),
        .rd_data1(aRd1), .rd_data2(aRd2), .rd_data3(aRd3),
        .busy1(aBusy1), .busy2(aBusy2), .busy3(aBusy3),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData[31:0]),
        .issue_en(issueEn), .issue_rd(issueRd),
        .waw_hazard(aWaw), .pending_vec(aPend)
    );

    fp_regfile_sb #(.XLEN(64), .NREGS(24), .ZERO_R0(1)) u_dutB (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1), .rs2_addr(rs2), .rs3_addr(rs3),
        .rd_data1(bRd1), .rd_data2(bRd2), .rd_data3(bRd3),
        .busy1(bBusy1), .busy2(bBusy2), .busy3(bBusy3),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .issue_en(issueEn), .issue_rd(issueRd),
        .waw_hazard(bWaw), .pending_vec(bPend)
    );

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled off-edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] expBypass;

    initial begin
        rst_n = 1'b0; rs1 = '0; rs2 = '0; rs3 = '0;
        wrEn = 1'b1; wrAddr = 5'd5; wrData = 64'h0000_0000_3F80_0000;
        issueEn = 1'b0; issueRd = '0;
        step();
        step();
        rst_n = 1'b1; wrEn = 1'b0;
        #1;
        for (int a = 0; a < 32; a++) begin
            rs1 = 5'(a); rs2 = 5'(a); rs3 = 5'(a);
            #1;
            checkVal($sformatf("rstData[%0d]", a), {32'h0, aRd1 | aRd2 | aRd3}, 64'h0);
            checkVal($sformatf("rstBusy[%0d]", a), {63'h0, aBusy1 | aBusy2 | aBusy3}, 64'h0);
        end
        checkVal("rstPendA", {32'h0, aPend}, 64'h0);
        checkVal("rstPendB", {40'h0, bPend}, 64'h0);
        rs1 = 5'd5; #1;
        checkVal("r5IgnoredInReset", {32'h0, aRd1}, 64'h0);

        // Issue r7, write it back two cycles later.
        rs1 = 5'd7; issueEn = 1'b1; issueRd = 5'd7; #1;
        checkVal("wawFirstIssue", {63'h0, aWaw}, 64'h0);
        step();
        issueEn = 1'b0; #1;
        checkVal("busyR7c1", {63'h0, aBusy1}, 64'h1);
        step();
        checkVal("busyR7c2", {63'h0, aBusy1}, 64'h1);
        wrEn = 1'b1; wrAddr = 5'd7; wrData = 64'h0000_0000_4049_0FDB; #1;
        checkVal("busyR7WrCycle", {63'h0, aBusy1}, 64'h0);
`ifdef FP_RF_BYPASS_EN
        expBypass = 32'h4049_0FDB;
`else
        expBypass = 32'h0;
`endif
        checkVal("rdR7WrCycle", {32'h0, aRd1}, {32'h0, expBypass});
        step();
        wrEn = 1'b0; #1;
        checkVal("rdR7After", {32'h0, aRd1}, 64'h4049_0FDB);
        checkVal("pendR7Cleared", {63'h0, aPend[7]}, 64'h0);

        // Simultaneous write and issue to r3: issue wins.
        wrEn = 1'b1; wrAddr = 5'd3; wrData = 64'h0000_0000_C000_0000;
        issueEn = 1'b1; issueRd = 5'd3;
        step();
        wrEn = 1'b0; issueEn = 1'b0; rs1 = 5'd3; #1;
        checkVal("rdR3", {32'h0, aRd1}, 64'hC000_0000);
        checkVal("pendR3", {63'h0, aPend[3]}, 64'h1);
        checkVal("busyR3", {63'h0, aBusy1}, 64'h1);
        issueEn = 1'b1; issueRd = 5'd3; #1;
        checkVal("wawR3", {63'h0, aWaw}, 64'h1);
        step();

        // r0: ordinary in A, hardwired zero in B.
        wrEn = 1'b1; wrAddr = 5'd0; wrData = 64'h0000_0000_1234_5678;
        issueEn = 1'b1; issueRd = 5'd0;
        step();
        wrEn = 1'b0; rs1 = 5'd0; #1;
        checkVal("aR0Data", {32'h0, aRd1}, 64'h1234_5678);
        checkVal("aR0Busy", {63'h0, aBusy1}, 64'h1);
        checkVal("aR0Waw", {63'h0, aWaw}, 64'h1);
        checkVal("bR0Data", bRd1, 64'h0);
        checkVal("bR0Busy", {63'h0, bBusy1}, 64'h0);
        checkVal("bR0Pend", {63'h0, bPend[0]}, 64'h0);
        checkVal("bR0Waw", {63'h0, bWaw}, 64'h0);
        step();
        issueEn = 1'b0;

        // Address 30 is beyond B's 24 entries.
        wrEn = 1'b1; wrAddr = 5'd30; wrData = 64'hDEAD_BEEF_CAFE_F00D;
        issueEn = 1'b1; issueRd = 5'd30;
        step();
        wrEn = 1'b0; issueEn = 1'b0; rs1 = 5'd30; #1;
        checkVal("bR30Data", bRd1, 64'h0);
        checkVal("bR30Busy", {63'h0, bBusy1}, 64'h0);
        checkVal("bPendOnlyR3", {40'h0, bPend}, 64'h0000_0008);
        checkVal("aR30Data", {32'h0, aRd1}, 64'hCAFE_F00D);
        checkVal("aPendR30", {63'h0, aPend[30]}, 64'h1);

        // Three aliased read ports.
        wrEn = 1'b1; wrAddr = 5'd9; wrData = 64'h7FF8_0000_7FC0_0000;
        step();
        wrEn = 1'b0; rs1 = 5'd9; rs2 = 5'd9; rs3 = 5'd9; #1;
        checkVal("aAlias1", {32'h0, aRd1}, 64'h7FC0_0000);
        checkVal("aAlias2", {32'h0, aRd2}, 64'h7FC0_0000);
        checkVal("aAlias3", {32'h0, aRd3}, 64'h7FC0_0000);
        checkVal("bAlias3", bRd3, 64'h7FF8_0000_7FC0_0000);
        wrEn = 1'b1; wrAddr = 5'd9; wrData = 64'h0000_0000_1111_2222; #1;
`ifdef FP_RF_BYPASS_EN
        expBypass = 32'h1111_2222;
`else
        expBypass = 32'h7FC0_0000;
`endif
        checkVal("aAliasWr2", {32'h0, aRd2}, {32'h0, expBypass});
        step();
        wrEn = 1'b0;

        // 64-bit write to B's last register, then reset.
        wrEn = 1'b1; wrAddr = 5'd23; wrData = 64'hFFFF_FFFF_3F80_0000;
        issueEn = 1'b1; issueRd = 5'd12;
        step();
        wrEn = 1'b0; issueEn = 1'b0; rs1 = 5'd23; #1;
        checkVal("bR23Data", bRd1, 64'hFFFF_FFFF_3F80_0000);
        checkVal("bPendR12", {63'h0, bPend[12]}, 64'h1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; #1;
        checkVal("bR23AfterRst", bRd1, 64'h0);
        checkVal("bPendAfterRst", {40'h0, bPend}, 64'h0);
        checkVal("aPendAfterRst", {32'h0, aPend}, 64'h0);
        rs1 = 5'd9; #1;
        checkVal("aR9AfterRst", {32'h0, aRd1}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
